ysyx_201979054_burst_addr_gen: RTL and testbench
================================================

YSYX_201979054_BURST_ADDR_GEN -- requirements
Module: ysyx_201979054_burst_addr_gen

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, meaning address bus width in bits.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning data bus width; maximum legal size is log2(AXI_DATA_WIDTH/8).
REQ-003 SHALL have parameter LEN_WIDTH, default 8, meaning width of the burst length field (AXI4 AxLEN).
REQ-004 SHALL have ports (clock and reset first):
  clk  in  1  single clock; all state changes on its rising edge
  arstn  in  1  reset, synchronous, active-low
  i_start  in  1  request a new burst; sampled only in IDLE
  i_abort  in  1  terminate the current burst immediately
  i_addr  in  AXI_ADDR_WIDTH  start address
  i_len  in  LEN_WIDTH  number of beats minus one
  i_size  in  3  bytes per beat = 2^i_size
  i_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
  i_ready  in  1  downstream accepts the current beat address
  o_valid  out  1  o_addr holds a valid beat address
  o_addr  out  AXI_ADDR_WIDTH  current beat address, registered
  o_last  out  1  current beat is the final beat
  o_busy  out  1  a burst is in progress
  o_done  out  1  one-cycle pulse after the final beat handshake
  o_err  out  1  one-cycle pulse when a request is rejected

Function
REQ-005 SHALL implement states IDLE and BURST; o_busy = (state == BURST).
REQ-006 SHALL, in IDLE with i_start=1 and a legal request, register i_addr into o_addr, load the beat counter with i_len and enter BURST; o_valid=1 on the following cycle.
REQ-007 SHALL treat a request as illegal if i_burst=11, i_size > log2(AXI_DATA_WIDTH/8), WRAP with i_len not in {1,3,7,15}, WRAP with i_addr not aligned to 2^i_size, or INCR whose byte span crosses a 4 KB boundary.
REQ-008 SHALL, on an illegal request, pulse o_err for one cycle, stay in IDLE and leave o_addr unchanged.
REQ-009 SHALL count a beat handshake only when o_valid=1 and i_ready=1; with i_ready=0, o_addr, o_last and the beat counter hold.
REQ-010 SHALL compute the next address on handshake: FIXED, unchanged; INCR, (addr & ~(2^size-1)) + 2^size; WRAP, with W=(len+1)*2^size, (addr & ~(W-1)) | ((addr + 2^size) & (W-1)).
REQ-011 SHALL perform all address arithmetic modulo 2^AXI_ADDR_WIDTH.
REQ-012 SHALL assert o_last when the beat counter equals 0; for i_len=0, o_last=1 on the first beat.
REQ-013 SHALL, on the handshake of the last beat, return to IDLE, drop o_valid and o_last, and pulse o_done on the next cycle.
REQ-014 SHALL ignore i_start while in BURST; a new burst starts no earlier than the cycle after o_done.
REQ-015 SHALL, on i_abort=1 in any state, enter IDLE next cycle with o_valid=0 and no o_done; i_abort has priority over i_start and handshakes.
REQ-016 SHALL latch i_size, i_burst and the wrap mask at start; input changes during BURST have no effect.

Reset
REQ-017 SHALL, when arstn=0 at a rising clk edge, enter IDLE with o_addr=0, o_valid=0, o_last=0, o_busy=0, o_done=0, o_err=0 and beat counter 0.
REQ-018 SHALL let reset mid-burst discard the burst without pulsing o_done or o_err.

Structure
REQ-019 SHALL place the burst_t enum (FIXED/INCR/WRAP/RSVD), the state enum and the 4 KB boundary constant in shared package ysyx_201979054_axi_pkg.
REQ-020 SHALL isolate the REQ-010 computation in combinational sub-module ysyx_201979054_next_addr.

Verification
REQ-021 SHALL cover INCR: addr 0x1000, size 2, len 3, i_ready=1 -> o_addr 0x1000,0x1004,0x1008,0x100C; o_last on 4th beat; o_done one cycle later.
REQ-022 SHALL cover WRAP: addr 0x1008, size 2, len 3 -> 0x1008,0x100C,0x1000,0x1004.
REQ-023 SHALL cover FIXED plus backpressure: addr 0x2000, len 2, i_ready low 3 cycles mid-burst -> 0x2000 held throughout; exactly 3 handshakes.
REQ-024 SHALL cover unaligned INCR: addr 0x1002, size 2, len 1 -> 0x1002,0x1004.
REQ-025 SHALL cover rejects: INCR 0x0FF8 size 2 len 3, WRAP len 2, burst=11 -> o_err pulse each, o_busy stays 0.
REQ-026 SHALL cover i_abort on 2nd beat and arstn=0 on 3rd beat of len 7 -> IDLE next cycle, o_valid=0, no o_done.

Source files
------------

// File: rtl/ysyx_201979054_axi_pkg.sv
// Shared AXI burst types and constants for the burst address generator.
package ysyx_201979054_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam int unsigned BOUNDARY_4K = 4096;

endpackage

// File: rtl/ysyx_201979054_next_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module ysyx_201979054_next_addr
    import ysyx_201979054_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [2:0]                size,
    input  burst_t                    burst,
    input  logic [AXI_ADDR_WIDTH-1:0] wrap_mask,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr
);

    logic [AXI_ADDR_WIDTH-1:0] step;

    always_comb begin
        step = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
        unique case (burst)
            BURST_INCR: next_addr = (addr & ~(step - 1'b1)) + step;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/ysyx_201979054_burst_addr_gen.sv
// AXI burst beat address generator: validates a request, then issues one
// registered beat address per handshake until the last beat or an abort.
module ysyx_201979054_burst_addr_gen
    import ysyx_201979054_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
    input  logic [LEN_WIDTH-1:0]      i_len,
    input  logic [2:0]                i_size,
    input  logic [1:0]                i_burst,
    input  logic                      i_ready,
    output logic                      o_valid,
    output logic [AXI_ADDR_WIDTH-1:0] o_addr,
    output logic                      o_last,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err
);

    localparam int unsigned MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);

    state_t                    state;
    logic [LEN_WIDTH-1:0]      cnt;
    logic [2:0]                size_q;
    burst_t                    burst_q;
    logic [AXI_ADDR_WIDTH-1:0] mask_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_nxt;

    burst_t                    req_burst;
    logic [AXI_ADDR_WIDTH-1:0] size_mask;
    logic [AXI_ADDR_WIDTH-1:0] req_wrap_mask;
    logic [23:0]               span_end;
    int unsigned               len_ext;
    logic                      legal;

    // 4 KB check uses the size-aligned start: the last byte touched is
    // aligned_start + (len+1)*2^size - 1, which must stay in the same page.
    always_comb begin
        req_burst     = burst_t'(i_burst);
        len_ext       = 32'(i_len);
        size_mask     = ({{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << i_size) - 1'b1;
        req_wrap_mask = ((AXI_ADDR_WIDTH'(i_len) + 1'b1) << i_size) - 1'b1;
        span_end      = 24'(i_addr[11:0] & ~size_mask[11:0]) + ((24'(i_len) + 24'd1) << i_size);
        legal         = 1'b1;
        if (req_burst == BURST_RSVD)
            legal = 1'b0;
        if (i_size > 3'(MAX_SIZE))
            legal = 1'b0;
        if (req_burst == BURST_WRAP) begin
            if (!(len_ext == 1 || len_ext == 3 || len_ext == 7 || len_ext == 15))
                legal = 1'b0;
            if ((i_addr & size_mask) != '0)
                legal = 1'b0;
        end
        if (req_burst == BURST_INCR && span_end > 24'(BOUNDARY_4K))
            legal = 1'b0;
    end

    ysyx_201979054_next_addr #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
    ) u_next_addr (
        .addr      (o_addr),
        .size      (size_q),
        .burst     (burst_q),
        .wrap_mask (mask_q),
        .next_addr (addr_nxt)
    );

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state   <= S_IDLE;
            o_addr  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            cnt     <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            mask_q  <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            if (i_abort) begin
                state   <= S_IDLE;
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            if (legal) begin
                                state   <= S_BURST;
                                o_addr  <= i_addr;
                                cnt     <= i_len;
                                o_valid <= 1'b1;
                                o_last  <= (i_len == '0);
                                size_q  <= i_size;
                                burst_q <= req_burst;
                                mask_q  <= req_wrap_mask;
                            end else begin
                                o_err <= 1'b1;
                            end
                        end
                    end
                    S_BURST: begin
                        if (o_valid && i_ready) begin
                            if (cnt == '0) begin
                                state   <= S_IDLE;
                                o_valid <= 1'b0;
                                o_last  <= 1'b0;
                                o_done  <= 1'b1;
                            end else begin
                                o_addr <= addr_nxt;
                                cnt    <= cnt - 1'b1;
                                o_last <= (cnt == LEN_WIDTH'(1));
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_busy = (state == S_BURST);

endmodule

// File: tb/tb_ysyx_201979054_burst_addr_gen.sv
// Directed self-checking bench for the burst address generator.
module tb_ysyx_201979054_burst_addr_gen;

    logic        clk = 1'b0;
    logic        arstn;
    logic        i_start, i_abort, i_ready;
    logic [63:0] i_addr;
    logic [7:0]  i_len;
    logic [2:0]  i_size;
    logic [1:0]  i_burst;
    logic        o_valid, o_last, o_busy, o_done, o_err;
    logic [63:0] o_addr;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_addr [16];

    always #5 clk = ~clk;

    ysyx_201979054_burst_addr_gen #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(32),
        .LEN_WIDTH     (8)
    ) dut (
        .clk     (clk),
        .arstn   (arstn),
        .i_start (i_start),
        .i_abort (i_abort),
        .i_addr  (i_addr),
        .i_len   (i_len),
        .i_size  (i_size),
        .i_burst (i_burst),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_addr  (o_addr),
        .o_last  (o_last),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [63:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        i_addr  = a;
        i_len   = len;
        i_size  = size;
        i_burst = burst;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Expects n beats from exp_addr with i_ready held high, then the done pulse.
    task automatic expect_beats(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, " valid"}, 64'(o_valid), 64'd1);
            check({tag, " addr"},  o_addr, exp_addr[i]);
            check({tag, " last"},  64'(o_last), 64'(i == n - 1));
            tick();
        end
        check({tag, " end valid"}, 64'(o_valid), 64'd0);
        check({tag, " end busy"},  64'(o_busy), 64'd0);
        check({tag, " done"},      64'(o_done), 64'd1);
        tick();
        check({tag, " done drop"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        int hs;
        logic seen_done;
        logic hs_now;
        arstn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b1;
        i_addr = 64'h0; i_len = 8'd0; i_size = 3'd0; i_burst = 2'b00;
        tick();
        tick();
        check("rst valid", 64'(o_valid), 64'd0);
        check("rst addr",  o_addr, 64'h0);
        check("rst last",  64'(o_last), 64'd0);
        check("rst busy",  64'(o_busy), 64'd0);
        check("rst done",  64'(o_done), 64'd0);
        check("rst err",   64'(o_err), 64'd0);
        arstn = 1'b1;
        tick();

        request(64'h1000, 8'd3, 3'd2, 2'b01);
        check("incr busy", 64'(o_busy), 64'd1);
        exp_addr[0] = 64'h1000; exp_addr[1] = 64'h1004;
        exp_addr[2] = 64'h1008; exp_addr[3] = 64'h100C;
        expect_beats("incr", 4);

        request(64'h1008, 8'd3, 3'd2, 2'b10);
        exp_addr[0] = 64'h1008; exp_addr[1] = 64'h100C;
        exp_addr[2] = 64'h1000; exp_addr[3] = 64'h1004;
        expect_beats("wrap", 4);

        // FIXED with i_ready low for three cycles after the first handshake
        request(64'h2000, 8'd2, 3'd2, 2'b00);
        hs = 0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            i_ready = (cyc >= 1 && cyc <= 3) ? 1'b0 : 1'b1;
            #1;
            hs_now = o_valid && i_ready;
            if (o_valid) begin
                check("fixed addr", o_addr, 64'h2000);
                check("fixed last", 64'(o_last), 64'(hs == 2));
            end
            @(posedge clk);
            #1;
            if (hs_now) hs++;
            if (o_done) seen_done = 1'b1;
        end
        i_ready = 1'b1;
        check("fixed handshakes", 64'(hs), 64'd3);
        check("fixed done seen",  64'(seen_done), 64'd1);
        tick();

        request(64'h1002, 8'd1, 3'd2, 2'b01);
        exp_addr[0] = 64'h1002; exp_addr[1] = 64'h1004;
        expect_beats("unaligned", 2);

        request(64'h0FF8, 8'd3, 3'd2, 2'b01);
        check("rej4k err",  64'(o_err), 64'd1);
        check("rej4k busy", 64'(o_busy), 64'd0);
        check("rej4k addr", o_addr, 64'h1004);
        tick();
        check("rej4k err drop", 64'(o_err), 64'd0);

        request(64'h1000, 8'd2, 3'd2, 2'b10);
        check("rejwrap err",  64'(o_err), 64'd1);
        check("rejwrap busy", 64'(o_busy), 64'd0);
        check("rejwrap valid", 64'(o_valid), 64'd0);
        tick();

        request(64'h1000, 8'd0, 3'd2, 2'b11);
        check("rejrsvd err",  64'(o_err), 64'd1);
        check("rejrsvd busy", 64'(o_busy), 64'd0);
        check("rejrsvd addr", o_addr, 64'h1004);
        tick();

        // Abort on the second beat of a len-7 INCR burst
        request(64'h3000, 8'd7, 3'd2, 2'b01);
        check("abort beat0", o_addr, 64'h3000);
        tick();
        check("abort beat1", o_addr, 64'h3004);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort valid", 64'(o_valid), 64'd0);
        check("abort busy",  64'(o_busy), 64'd0);
        check("abort done",  64'(o_done), 64'd0);
        check("abort last",  64'(o_last), 64'd0);
        tick();
        check("abort done later", 64'(o_done), 64'd0);

        // Reset on the third beat
        request(64'h3000, 8'd7, 3'd2, 2'b01);
        tick();
        tick();
        check("rstmid beat2", o_addr, 64'h3008);
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        check("rstmid valid", 64'(o_valid), 64'd0);
        check("rstmid busy",  64'(o_busy), 64'd0);
        check("rstmid addr",  o_addr, 64'h0);
        check("rstmid done",  64'(o_done), 64'd0);
        check("rstmid err",   64'(o_err), 64'd0);
        tick();
        check("rstmid done later", 64'(o_done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
